// File: rtl/add_accumulator.sv
// Streaming accumulator around a 32-bit carry-select adder: sums len operands, then presents one result beat.
// Optional ADD_ACC_SATURATE_EN: clamp the accumulator to all-ones once any beat carries out.
module add_accumulator_csa #(
    parameter int WIDTH = 32,
    parameter int BLK   = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    localparam int NB = WIDTH / BLK;

    logic [NB:0] w_c;
    assign w_c[0] = 1'b0;

    // Each block precomputes both carry-in cases; the incoming carry just selects.
    for (genvar gi = 0; gi < NB; gi++) begin : g_blk
        logic [BLK:0] w_s0, w_s1;
        assign w_s0 = {1'b0, i_a[gi*BLK +: BLK]} + {1'b0, i_b[gi*BLK +: BLK]};
        assign w_s1 = {1'b0, i_a[gi*BLK +: BLK]} + {1'b0, i_b[gi*BLK +: BLK]} + (BLK+1)'(1);
        assign o_sum[gi*BLK +: BLK] = w_c[gi] ? w_s1[BLK-1:0] : w_s0[BLK-1:0];
        assign w_c[gi+1]            = w_c[gi] ? w_s1[BLK]     : w_s0[BLK];
    end

    assign o_cout = w_c[NB];
endmodule

module add_accumulator #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic [CNT_W-1:0] out_count
);
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_len;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_beat;

    add_accumulator_csa #(.WIDTH(WIDTH), .BLK(8)) u_add (
        .i_a    (r_acc),
        .i_b    (in_data),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_beat = (r_state == S_ACCUM) && in_valid && r_in_ready;

`ifdef ADD_ACC_SATURATE_EN
    // Once saturated the accumulator stays pinned for the rest of the job.
    assign w_acc_nxt = (w_cout || r_carry) ? {WIDTH{1'b1}} : w_sum;
`else
    assign w_acc_nxt = w_sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc   <= '0;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                        r_len   <= len;
                        if (len != '0) begin
                            r_state    <= S_ACCUM;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_beat) begin
                        r_acc   <= w_acc_nxt;
                        r_carry <= r_carry | w_cout;
                        r_cnt   <= r_cnt + CNT_W'(1);
                        if (r_cnt == r_len - CNT_W'(1)) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_acc;
    assign out_carry = r_carry;
    assign out_count = r_cnt;
endmodule

// File: tb/tb_add_accumulator.sv
// Directed bench for add_accumulator; expected values are hand-computed constants.
module tb_add_accumulator;
    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic [CNT_W-1:0] out_count;

    int n_chk  = 0;
    int n_pass = 0;

    add_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Inputs change and outputs are sampled 1ns after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_job(input logic [CNT_W-1:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_carry", out_carry, 0);
        chk("rst_out_count", out_count, 0);

        // basic sum, back-to-back beats
        begin_job(8'd4);
        chk("basic_in_ready", in_ready, 1);
        send(1); send(2); send(3);
        chk("basic_no_early_valid", out_valid, 0);
        send(4);
        chk("basic_out_valid", out_valid, 1);
        chk("basic_sum", out_sum, 10);
        chk("basic_carry", out_carry, 0);
        chk("basic_count", out_count, 4);
        drain();
        chk("basic_idle_valid", out_valid, 0);

        // wrap / saturate
        begin_job(8'd2);
        send(32'hFFFF_FFFF); send(32'h0000_0002);
`ifdef ADD_ACC_SATURATE_EN
        chk("wrap_sum", out_sum, 32'hFFFF_FFFF);
`else
        chk("wrap_sum", out_sum, 32'h0000_0001);
`endif
        chk("wrap_carry", out_carry, 1);
        chk("wrap_count", out_count, 2);
        drain();

        // in_valid toggling: only accepted beats count
        begin_job(8'd3);
        send(5);
        in_data = 100; tick();
        send(6);
        in_data = 200; tick();
        send(7);
        chk("stall_valid", out_valid, 1);
        chk("stall_sum", out_sum, 18);
        chk("stall_count", out_count, 3);

        // downstream backpressure; operands and starts offered in DONE are ignored
        in_valid = 1'b1; in_data = 999; start = 1'b1; len = 8'd9;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_sum", out_sum, 18);
            chk("bp_count", out_count, 3);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; start = 1'b0;
        chk("hs_valid_drop", out_valid, 0);
        chk("hs_start_ignored", in_ready, 0);
        tick();
        chk("hs_still_idle", in_ready, 0);

        // zero-length job
        in_valid = 1'b1; in_data = 55;
        begin_job(8'd0);
        chk("len0_valid", out_valid, 1);
        chk("len0_in_ready", in_ready, 0);
        tick();
        chk("len0_sum", out_sum, 0);
        chk("len0_count", out_count, 0);
        in_valid = 1'b0;
        drain();

        // reset mid-job
        begin_job(8'd5);
        send(10); send(20);
        chk("mid_partial", out_sum, 30);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_sum", out_sum, 0);
        chk("mid_rst_count", out_count, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_valid", out_valid, 0);
        begin_job(8'd1);
        send(7);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_sum", out_sum, 7);
        chk("post_rst_count", out_count, 1);
        drain();

        // maximum length with a stray start mid-job
        begin_job(8'd255);
        for (int i = 0; i < 254; i++) begin
            if (i == 100) begin
                start = 1'b1; len = 8'd3;
            end
            send(1);
            start = 1'b0;
        end
        chk("max_not_done", out_valid, 0);
        chk("max_partial", out_count, 254);
        send(1);
        chk("max_valid", out_valid, 1);
        chk("max_sum", out_sum, 255);
        chk("max_count", out_count, 255);
        chk("max_carry", out_carry, 0);
        drain();
        chk("max_idle", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
